// File: rtl/seq_bit_serializer_if.sv
// Handshake and serial-output bundle between an upstream word source and seq_bit_serializer.
interface seq_bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] Din;
  logic             Din_Vld;
  logic             Din_Rdy;
  logic             B;
  logic             B_Vld;
  logic             Busy;
  logic             Word_Done;

  modport slave (
    input  Din, Din_Vld,
    output Din_Rdy, B, B_Vld, Busy, Word_Done
  );

  modport master (
    output Din, Din_Vld,
    input  Din_Rdy, B, B_Vld, Busy, Word_Done
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words and streams them one bit per Clk on B,
// chaining consecutive words with no idle bit between them.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  seq_bit_serializer_if.slave  bus
);

  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             b_q, b_n;
  logic             bvld_q, bvld_n;
  logic             busy_q, busy_n;
  logic             wd_q, wd_n;
  logic             accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign bus.Din_Rdy   = Rst && ((state == IDLE) || (cnt == LAST));
  assign accept        = bus.Din_Vld && bus.Din_Rdy;
  assign bus.B         = b_q;
  assign bus.B_Vld     = bvld_q;
  assign bus.Busy      = busy_q;
  assign bus.Word_Done = wd_q;

  // B is registered, so the shift register keeps only the bits not yet presented;
  // a load drops the first bit straight into b_n and stores the remainder.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    b_n     = IDLE_BIT;
    bvld_n  = 1'b0;
    busy_n  = 1'b0;
    wd_n    = 1'b0;
    if (accept) begin
      state_n = SHIFT;
      sreg_n  = advance(bus.Din);
      cnt_n   = '0;
      b_n     = first_bit(bus.Din);
      bvld_n  = 1'b1;
      busy_n  = 1'b1;
    end else if ((state == SHIFT) && (cnt != LAST)) begin
      sreg_n  = advance(sreg);
      cnt_n   = cnt + 1'b1;
      b_n     = first_bit(sreg);
      bvld_n  = 1'b1;
      busy_n  = 1'b1;
      wd_n    = (cnt_n == LAST);
    end else begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      b_q    <= IDLE_BIT;
      bvld_q <= 1'b0;
      busy_q <= 1'b0;
      wd_q   <= 1'b0;
    end else begin
      state  <= state_n;
      sreg   <= sreg_n;
      cnt    <= cnt_n;
      b_q    <= b_n;
      bvld_q <= bvld_n;
      busy_q <= busy_n;
      wd_q   <= wd_n;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Checks MSB-first and LSB-first serializers side by side against a bit-queue reference model.
module tb_seq_bit_serializer;

  logic Clk;
  logic Rst;
  int   tests;
  int   fails;

  seq_bit_serializer_if #(.WIDTH(8)) bm ();
  seq_bit_serializer_if #(.WIDTH(8)) bl ();

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bm)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bl)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: queue of bits still to appear on B; element 0 is the bit on B this cycle.
  bit qm[$];
  bit ql[$];

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic vld, input logic [7:0] din, output bit acc);
    bit rdy;
    @(negedge Clk);
    Rst        = rst;
    bm.Din     = din;
    bm.Din_Vld = vld;
    bl.Din     = din;
    bl.Din_Vld = vld;
    #1;
    rdy = rst && (qm.size() <= 1);
    chk("msb_rdy",  bm.Din_Rdy,   rdy);
    chk("msb_bvld", bm.B_Vld,     qm.size() > 0);
    chk("msb_b",    bm.B,         (qm.size() > 0) ? qm[0] : 1'b0);
    chk("msb_busy", bm.Busy,      qm.size() > 0);
    chk("msb_done", bm.Word_Done, qm.size() == 1);
    chk("lsb_rdy",  bl.Din_Rdy,   rdy);
    chk("lsb_bvld", bl.B_Vld,     ql.size() > 0);
    chk("lsb_b",    bl.B,         (ql.size() > 0) ? ql[0] : 1'b0);
    chk("lsb_busy", bl.Busy,      ql.size() > 0);
    chk("lsb_done", bl.Word_Done, ql.size() == 1);
    acc = rdy && vld;
    @(posedge Clk);
    if (!rst) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (acc) begin
        for (int unsigned k = 0; k < 8; k++) begin
          qm.push_back(din[7-k]);
          ql.push_back(din[k]);
        end
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    bit a;
    for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, a);
  endtask

  // Holds the word valid until the model accepts it; an expired budget counts as a failure.
  task automatic send(input logic [7:0] w);
    bit a;
    a = 1'b0;
    for (int unsigned i = 0; i < 20 && !a; i++) step(1'b1, 1'b1, w, a);
    chk("send_accept", a, 1'b1);
  endtask

  initial begin
    bit a;
    tests      = 0;
    fails      = 0;
    Rst        = 1'b0;
    bm.Din     = 8'hFF;
    bm.Din_Vld = 1'b1;
    bl.Din     = 8'hFF;
    bl.Din_Vld = 1'b1;

    // Reset held with a valid word offered: nothing may be accepted.
    step(1'b0, 1'b1, 8'hFF, a);
    step(1'b0, 1'b1, 8'hFF, a);
    idle(2);

    // Single word, then drain to idle.
    send(8'hB4);
    idle(10);

    // Back-to-back words with valid held high.
    send(8'hB4);
    send(8'h0F);
    idle(10);

    // 8'h06: LSB-first instance emits 0,1,1,0,0,0,0,0.
    send(8'h06);
    idle(10);

    // Backpressure: A5 offered while busy, replaced by 3C before ready rises.
    send(8'hB4);
    step(1'b1, 1'b1, 8'hA5, a);
    step(1'b1, 1'b1, 8'hA5, a);
    step(1'b1, 1'b1, 8'hA5, a);
    send(8'h3C);
    idle(10);

    // Reset while the third bit is on B abandons the word.
    send(8'hB4);
    idle(2);
    step(1'b0, 1'b0, 8'h00, a);
    idle(2);
    send(8'h81);
    idle(10);

    // Randomized traffic with occasional resets.
    for (int unsigned i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0), 8'($urandom), a);
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
